// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback wins, long-latency results queue in a FIFO.
// Optional same-cycle bypass of an idle port is enabled by defining WB_BYPASS_EN.
module wb_port_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 4,
    parameter int DATA_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipe_wr_en,
    input  logic [2:0]        pipe_wr_reg,
    input  logic [DATA_W-1:0] pipe_wr_data,
    input  logic              ll_valid,
    input  logic [2:0]        ll_reg,
    input  logic [DATA_W-1:0] ll_data,
    output logic              ll_ready,
    output logic              rf_wr_en,
    output logic [2:0]        rf_wr_reg,
    output logic [DATA_W-1:0] rf_wr_data,
    output logic [7:0]        busy_mask,
    output logic              stall_req
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    logic [2:0]        ent_reg  [DEPTH];
    logic [DATA_W-1:0] ent_data [DEPTH];
    logic [DEPTH-1:0]  ent_valid;
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;
    logic [STV_W-1:0]  starve;
    logic              full;
    logic              empty;
    logic              bypass;
    logic              push;
    logic              pop;
    logic              starve_max;

    assign full       = (count == CNT_W'(DEPTH));
    assign empty      = (count == '0);
    assign starve_max = (starve == STV_W'(STARVE_LIMIT));
    assign ll_ready   = !rst && !full;
    assign stall_req  = !rst && (full || starve_max);

`ifdef WB_BYPASS_EN
    assign bypass = !pipe_wr_en && empty && ll_valid;
`else
    assign bypass = 1'b0;
`endif

    // A squashed head still pops on an idle port cycle, it just writes nothing.
    assign push = ll_valid && !full && !bypass;
    assign pop  = !pipe_wr_en && !empty;

    always_comb begin
        rf_wr_en   = 1'b0;
        rf_wr_reg  = pipe_wr_reg;
        rf_wr_data = pipe_wr_data;
        if (!rst) begin
            if (pipe_wr_en) begin
                rf_wr_en = 1'b1;
            end else if (bypass) begin
                rf_wr_en   = 1'b1;
                rf_wr_reg  = ll_reg;
                rf_wr_data = ll_data;
            end else if (!empty && ent_valid[head]) begin
                rf_wr_en   = 1'b1;
                rf_wr_reg  = ent_reg[head];
                rf_wr_data = ent_data[head];
            end
        end
    end

    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i]) begin
                busy_mask[ent_reg[i]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ent_reg[tail]  <= ll_reg;
            ent_data[tail] <= ll_data;
        end
    end

    // A newer pipeline write to the same register makes older buffered results obsolete.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            ent_valid <= '0;
            starve    <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (pipe_wr_en && ent_reg[i] == pipe_wr_reg) begin
                    ent_valid[i] <= 1'b0;
                end
            end
            if (pop) begin
                ent_valid[head] <= 1'b0;
                head            <= head + 1'b1;
            end
            if (push) begin
                ent_valid[tail] <= !(pipe_wr_en && ll_reg == pipe_wr_reg);
                tail            <= tail + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (pipe_wr_en && !empty) begin
                starve <= starve_max ? starve : starve + 1'b1;
            end else begin
                starve <= '0;
            end
        end
    end
endmodule
